// File: rtl/cpu0_bus_pkg.sv
// cpu0_bus_pkg: bus encodings shared by the cpu0 core, memory and IO blocks.
// Holds size codes, console register offsets and the console base address.
package cpu0_bus_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'b00,
      SZ_INT16 = 2'b01,
      SZ_INT24 = 2'b10,
      SZ_INT32 = 2'b11
   } m_size_t;

   localparam logic [31:0] IO_CONSOLE_BASE = 32'h0008_0000;

   localparam logic [3:0] REG_DATA   = 4'h0;
   localparam logic [3:0] REG_STATUS = 4'h4;
   localparam logic [3:0] REG_CTRL   = 4'h8;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   function automatic logic [2:0] size_bytes(input m_size_t sz);
      return {1'b0, sz} + 3'd1;
   endfunction

endpackage

// File: rtl/io_byte_fifo.sv
// io_byte_fifo: single-clock byte FIFO with occupancy level.
// A push while full is dropped unless a pop frees a slot on the same clock.
module io_byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [7:0]               din,
   input  logic                     pop,
   output logic [7:0]               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == (AW + 1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)
            level <= level + (AW + 1)'(1);
         else if (!do_push && do_pop)
            level <= level - (AW + 1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/io_console_tx.sv
// io_console_tx: memory-mapped console transmitter for the cpu0 bus.
// Bytes written to DATA are queued and shifted out as 8N1 serial frames.
module io_console_tx
   import cpu0_bus_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = IO_CONSOLE_BASE,
   parameter int          FIFO_DEPTH   = 16,
   parameter int          CLKS_PER_BIT = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        en,
   input  logic        rw,
   input  logic [1:0]  m_size,
   input  logic [31:0] abus,
   input  logic [31:0] dbus_in,
   output logic [31:0] dbus_out,
   output logic        txd,
   output logic        irq
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   logic          armed;
   logic          acc;
   logic          wr_data;
   logic          wr_ctrl;
   logic          rd_status;
   logic          rd_ctrl;
   logic          rd_act;
   logic [31:0]   rd_q;
   logic [31:0]   status;
   logic          irq_en;
   logic          ovf;
   logic          ovf_set;
   logic          drop_busy;
   logic          load;
   logic          busy;
   logic [31:0]   up_buf;
   logic [2:0]    up_cnt;
   logic          up_raw;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic          fifo_drop;
   logic [7:0]    fifo_dout;
   logic [LW-1:0] level;
   tx_state_t     state;
   tx_state_t     state_n;
   logic [CW-1:0] baud;
   logic [CW-1:0] baud_n;
   logic [2:0]    bitn;
   logic [2:0]    bitn_n;
   logic [7:0]    shf;
   logic [7:0]    shf_n;
   logic          tick;

   // One access per en pulse: armed drops on acceptance until en is seen low.
   assign acc       = en && armed && (abus[31:4] == BASE_ADDR[31:4]);
   assign wr_data   = acc && !rw && (abus[3:0] == REG_DATA);
   assign wr_ctrl   = acc && !rw && (abus[3:0] == REG_CTRL);
   assign rd_status = acc &&  rw && (abus[3:0] == REG_STATUS);
   assign rd_ctrl   = acc &&  rw && (abus[3:0] == REG_CTRL);

   assign busy      = (up_cnt != 3'd0);
   assign drop_busy = wr_data && busy;
   assign load      = wr_data && !busy &&
                      ((m_size == SZ_BYTE) || (dbus_in[7:0] != 8'h00));
   assign push      = busy && (up_raw || (up_buf[7:0] != 8'h00));
   assign fifo_drop = push && full && !pop;
   assign ovf_set   = drop_busy || fifo_drop;

   assign status   = {22'b0, 6'(level), ovf, busy, full, empty};
   assign dbus_out = (rd_act && en && !reset) ? rd_q : 32'hzzzz_zzzz;
   assign irq      = irq_en && empty;

   always_ff @(posedge clock) begin
      if (reset) begin
         armed  <= 1'b1;
         rd_act <= 1'b0;
         rd_q   <= '0;
         irq_en <= 1'b0;
         ovf    <= 1'b0;
         up_buf <= '0;
         up_cnt <= '0;
         up_raw <= 1'b0;
      end else begin
         if (!en)
            armed <= 1'b1;
         else if (acc)
            armed <= 1'b0;

         if (!en) begin
            rd_act <= 1'b0;
         end else if (rd_status || rd_ctrl) begin
            rd_act <= 1'b1;
            rd_q   <= rd_status ? status : {31'b0, irq_en};
         end

         if (wr_ctrl) irq_en <= dbus_in[0];

         ovf <= ovf_set || (ovf && !rd_status);

         // Byte writes go through the unpacker too, flagged raw so 8'h00 is kept.
         if (busy) begin
            up_buf <= up_buf >> 8;
            up_cnt <= up_cnt - 3'd1;
         end else if (load) begin
            up_buf <= dbus_in;
            up_cnt <= size_bytes(m_size_t'(m_size));
            up_raw <= (m_size == SZ_BYTE);
         end
      end
   end

   io_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .din   (up_buf[7:0]),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   assign tick = (baud == BAUD_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= TX_IDLE;
         baud  <= '0;
         bitn  <= '0;
         shf   <= '0;
      end else begin
         state <= state_n;
         baud  <= baud_n;
         bitn  <= bitn_n;
         shf   <= shf_n;
      end
   end

   always_comb begin
      state_n = state;
      baud_n  = baud;
      bitn_n  = bitn;
      shf_n   = shf;
      pop     = 1'b0;
      txd     = 1'b1;
      unique case (state)
         TX_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shf_n   = fifo_dout;
               baud_n  = '0;
               state_n = TX_START;
            end
         end
         TX_START: begin
            txd = 1'b0;
            if (tick) begin
               baud_n  = '0;
               bitn_n  = '0;
               state_n = TX_DATA;
            end else begin
               baud_n = baud + CW'(1);
            end
         end
         TX_DATA: begin
            txd = shf[0];
            if (tick) begin
               baud_n = '0;
               shf_n  = shf >> 1;
               bitn_n = bitn + 3'd1;
               if (bitn == 3'd7) state_n = TX_STOP;
            end else begin
               baud_n = baud + CW'(1);
            end
         end
         TX_STOP: begin
            // Reload straight from the FIFO so frames run back to back.
            if (tick) begin
               baud_n = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  shf_n   = fifo_dout;
                  state_n = TX_START;
               end else begin
                  state_n = TX_IDLE;
               end
            end else begin
               baud_n = baud + CW'(1);
            end
         end
      endcase
   end

endmodule

// File: tb/tb_io_console_tx.sv
// tb_io_console_tx: bus-level stimulus with a serial-line decoder and
// a byte-queue reference model of what the console must transmit.
module tb_io_console_tx;
   import cpu0_bus_pkg::*;

   localparam int          CPB   = 16;
   localparam int          FRAME = 10 * CPB;
   localparam logic [31:0] BASE  = 32'h0008_0000;

   logic        clock   = 1'b0;
   logic        reset   = 1'b1;
   logic        en      = 1'b0;
   logic        rw      = 1'b0;
   logic [1:0]  m_size  = 2'b00;
   logic [31:0] abus    = '0;
   logic [31:0] dbus_in = '0;
   wire  [31:0] dbus_out;
   logic        txd;
   logic        irq;

   io_console_tx #(
      .BASE_ADDR    (BASE),
      .FIFO_DEPTH   (16),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .en       (en),
      .rw       (rw),
      .m_size   (m_size),
      .abus     (abus),
      .dbus_in  (dbus_in),
      .dbus_out (dbus_out),
      .txd      (txd),
      .irq      (irq)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int         n_chk  = 0;
   int         n_pass = 0;
   logic [7:0] exp_q[$];
   int         starts[$];
   int         frames = 0;
   bit         mon_on = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   task automatic bus_wr(input logic [31:0] off, input logic [1:0] sz,
                         input logic [31:0] d, output int acc);
      @(negedge clock);
      en = 1'b1; rw = 1'b0; abus = BASE + off; m_size = sz; dbus_in = d;
      @(negedge clock);
      acc = cyc;
      en  = 1'b0;
   endtask

   task automatic bus_rd(input logic [31:0] off, output logic [31:0] d);
      @(negedge clock);
      en = 1'b1; rw = 1'b1; abus = BASE + off; m_size = SZ_INT32;
      @(negedge clock);
      d  = dbus_out;
      en = 1'b0;
   endtask

   // What the line should carry for one DATA write, assuming no overflow.
   task automatic model_wr(input logic [1:0] sz, input logic [31:0] d);
      if (sz == 2'b00) begin
         exp_q.push_back(d[7:0]);
      end else if (d[7:0] != 8'h00) begin
         for (int i = 0; i <= int'(sz); i++)
            if (d[8*i +: 8] != 8'h00) exp_q.push_back(d[8*i +: 8]);
      end
   endtask

   task automatic wait_frames(input int n, input int budget);
      int k;
      k = 0;
      while (frames < n && k < budget) begin
         @(negedge clock);
         k++;
      end
      chk("wait_frames", 32'(frames >= n), 32'd1);
   endtask

   // Serial decoder: samples mid-bit on negedges, ignores frames cut by reset.
   initial begin
      int         t0;
      logic [7:0] b;
      logic       st;
      logic       sb;
      bit         ab;
      wait (mon_on);
      forever begin
         @(negedge clock);
         if (txd === 1'b0 && !reset) begin
            t0 = cyc;
            ab = 1'b0;
            repeat (CPB / 2) begin
               @(negedge clock);
               if (reset) ab = 1'b1;
            end
            sb = txd;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) begin
                  @(negedge clock);
                  if (reset) ab = 1'b1;
               end
               b[i] = txd;
            end
            repeat (CPB) begin
               @(negedge clock);
               if (reset) ab = 1'b1;
            end
            st = txd;
            if (!ab) begin
               chk("start_bit", 32'(sb), 32'd0);
               chk("stop_bit", 32'(st), 32'd1);
               chk("frame_pending", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0)
                  chk("frame_byte", 32'(b), 32'(exp_q.pop_front()));
               starts.push_back(t0);
               frames++;
            end
         end
      end
   end

   initial begin
      #(10 * 95000);
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [31:0] d;
      logic [1:0]  sz;
      logic [7:0]  bv;
      int          acc;
      int          f0;
      int          n;
      int          k;

      repeat (3) @(negedge clock);
      chk("rst_txd", 32'(txd), 32'd1);
      chk("rst_irq", 32'(irq), 32'd0);
      reset  = 1'b0;
      mon_on = 1'b1;

      bus_rd(32'(REG_STATUS), rd);
      chk("rst_status", rd, 32'h0000_0001);
      bus_rd(32'(REG_CTRL), rd);
      chk("rst_ctrl", rd, 32'h0000_0000);

      // single byte: latency and bit order
      f0 = frames;
      bus_wr(32'(REG_DATA), SZ_BYTE, 32'h0000_0041, acc);
      model_wr(SZ_BYTE, 32'h0000_0041);
      @(negedge clock);
      chk("txd_plus1", 32'(txd), 32'd1);
      @(negedge clock);
      chk("txd_plus2", 32'(txd), 32'd0);
      wait_frames(f0 + 1, FRAME + 100);
      chk("first_edge", 32'(starts[starts.size() - 1] - acc), 32'd2);

      // int32 unpack, write while busy, back-to-back frames
      f0 = frames;
      bus_wr(32'(REG_DATA), SZ_INT32, 32'h0043_4241, acc);
      model_wr(SZ_INT32, 32'h0043_4241);
      bus_wr(32'(REG_DATA), SZ_BYTE, 32'h0000_005A, acc);
      bus_rd(32'(REG_STATUS), rd);
      chk("busy_ovf", rd & 32'hC, 32'hC);
      wait_frames(f0 + 3, 3 * FRAME + 100);
      n = starts.size();
      chk("gap_ab", 32'(starts[n-2] - starts[n-3]), 32'(FRAME));
      chk("gap_bc", 32'(starts[n-1] - starts[n-2]), 32'(FRAME));

      f0 = frames;
      bus_wr(32'(REG_DATA), SZ_INT32, 32'h4142_4300, acc);
      model_wr(SZ_INT32, 32'h4142_4300);
      repeat (FRAME + 50) @(negedge clock);
      chk("zero_lsb_discard", 32'(frames), 32'(f0));

      // overflow: one byte in the shifter, sixteen in the FIFO, one dropped
      f0 = frames;
      for (int i = 0; i < 18; i++) begin
         bv = 8'($urandom_range(1, 255));
         bus_wr(32'(REG_DATA), SZ_BYTE, {24'b0, bv}, acc);
         if (i < 17) exp_q.push_back(bv);
      end
      bus_rd(32'(REG_STATUS), rd);
      chk("status_full_ovf", rd, {22'b0, 6'd16, 1'b1, 1'b0, 1'b1, 1'b0});
      bus_rd(32'(REG_STATUS), rd);
      chk("status_ovf_clr", rd, {22'b0, 6'd16, 1'b0, 1'b0, 1'b1, 1'b0});
      wait_frames(f0 + 17, 17 * FRAME + 200);

      // interrupt follows FIFO empty while enabled
      bus_wr(32'(REG_CTRL), SZ_INT32, 32'h0000_0001, acc);
      chk("irq_enabled", 32'(irq), 32'd1);
      bus_rd(32'(REG_CTRL), rd);
      chk("ctrl_rb1", rd, 32'h0000_0001);
      f0 = frames;
      bus_wr(32'(REG_DATA), SZ_BYTE, 32'h0000_0033, acc);
      model_wr(SZ_BYTE, 32'h0000_0033);
      @(negedge clock);
      chk("irq_push", 32'(irq), 32'd0);
      @(negedge clock);
      chk("irq_pop", 32'(irq), 32'd1);
      wait_frames(f0 + 1, FRAME + 100);
      bus_wr(32'(REG_CTRL), SZ_INT32, 32'h0000_0000, acc);
      chk("irq_disabled", 32'(irq), 32'd0);

      // en held for three clocks
      f0 = frames;
      @(negedge clock);
      en = 1'b1; rw = 1'b0; abus = BASE; m_size = SZ_BYTE; dbus_in = 32'h77;
      repeat (3) @(negedge clock);
      en = 1'b0;
      model_wr(SZ_BYTE, 32'h0000_0077);
      wait_frames(f0 + 1, FRAME + 100);
      repeat (FRAME) @(negedge clock);
      chk("single_push", 32'(frames), 32'(f0 + 1));

      // unmapped offsets and out-of-block address
      f0 = frames;
      bus_wr(32'h0000_000C, SZ_BYTE, 32'h0000_0055, acc);
      bus_wr(32'(REG_STATUS), SZ_BYTE, 32'h0000_0055, acc);
      bus_wr(32'h0000_0001, SZ_BYTE, 32'h0000_0055, acc);
      bus_wr(32'h0000_0010, SZ_BYTE, 32'h0000_0055, acc);
      repeat (FRAME + 50) @(negedge clock);
      chk("unmapped", 32'(frames), 32'(f0));

      // randomized writes of every size, mixed with CTRL traffic
      for (int it = 0; it < 24; it++) begin
         if ($urandom_range(0, 3) == 3) begin
            d = {31'b0, 1'($urandom_range(0, 1))};
            bus_wr(32'(REG_CTRL), SZ_INT32, d, acc);
            bus_rd(32'(REG_CTRL), rd);
            chk("ctrl_rb", rd, d);
         end else begin
            k = 0;
            while (exp_q.size() > 8 && k < 4000) begin
               @(negedge clock);
               k++;
            end
            if (k >= 4000) chk("flow_wait", 32'(exp_q.size()), 32'd8);
            d  = $urandom;
            for (int b = 0; b < 4; b++)
               if ($urandom_range(0, 3) == 0) d[8*b +: 8] = 8'h00;
            sz = 2'($urandom_range(0, 3));
            bus_wr(32'(REG_DATA), sz, d, acc);
            model_wr(sz, d);
            repeat (6) @(negedge clock);
         end
      end
      k = 0;
      while (exp_q.size() != 0 && k < 20000) begin
         @(negedge clock);
         k++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);

      // reset in the middle of data bit 3
      bus_wr(32'(REG_CTRL), SZ_INT32, 32'h0000_0001, acc);
      f0 = frames;
      bus_wr(32'(REG_DATA), SZ_BYTE, 32'h0000_0055, acc);
      model_wr(SZ_BYTE, 32'h0000_0055);
      repeat (2 + CPB + 3 * CPB + CPB / 2) @(negedge clock);
      reset = 1'b1;
      exp_q.delete();
      @(negedge clock);
      chk("rst_mid_txd", 32'(txd), 32'd1);
      chk("rst_mid_irq", 32'(irq), 32'd0);
      reset = 1'b0;
      bus_rd(32'(REG_STATUS), rd);
      chk("rst_mid_status", rd, 32'h0000_0001);
      bus_rd(32'(REG_CTRL), rd);
      chk("rst_mid_ctrl", rd, 32'h0000_0000);
      repeat (2 * FRAME) @(negedge clock);
      chk("no_frame_after_rst", 32'(frames), 32'(f0));

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
